// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit for a five-stage in-order core.
// It drives stalls, bubbles and ALU operand forwarding, freezes the whole
// pipeline while a data-memory access is outstanding, and counts stalled
// fetch cycles.
// Build option: define HAZARD_FORWARDING_EN to enable operand forwarding.
// Without it, every in-flight register write that Decode depends on
// stalls Decode, and the forward selects stay at the register file.
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteE,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        ResultSrcE,
  input  logic        PCSrcE,
  input  logic        MemReqM,
  input  logic        MemReadyM,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushW,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic [31:0] StallCount
);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t      state_r;
  logic [31:0] stall_count_r;
  logic        mem_freeze_s;
  logic        data_stall_s;

  // True when a non-zero destination matches either Decode source.
  function automatic logic dec_hit(input logic [4:0] rd,
                                   input logic [4:0] rs1,
                                   input logic [4:0] rs2);
    return (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
  endfunction

  // Freeze starts in the very cycle of the miss and lasts until ready.
  assign mem_freeze_s = ~MemReadyM & (MemReqM | (state_r == MEM_WAIT));

`ifdef HAZARD_FORWARDING_EN
  logic unused_fwd_s;

  // Operand select: Memory result beats Writeback result; x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (RegWriteM && (RdM != 5'd0) && (RdM == rs)) begin
      return 2'b10;
    end else if (RegWriteW && (RdW != 5'd0) && (RdW == rs)) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
  endfunction

  // With forwarding, only a load result is still unavailable to Decode.
  assign data_stall_s = ResultSrcE & dec_hit(RdE, Rs1D, Rs2D);
  assign ForwardAE    = fwd_sel(Rs1E);
  assign ForwardBE    = fwd_sel(Rs2E);
  assign unused_fwd_s = RegWriteE;
`else
  logic unused_fwd_s;

  // Without forwarding, any pending write in Execute or Memory must retire
  // first; Writeback writes are visible through the register file.
  assign data_stall_s = (RegWriteE & dec_hit(RdE, Rs1D, Rs2D)) |
                        (RegWriteM & dec_hit(RdM, Rs1D, Rs2D));
  assign ForwardAE    = 2'b00;
  assign ForwardBE    = 2'b00;
  assign unused_fwd_s = ^{Rs1E, Rs2E, RdW, RegWriteW, ResultSrcE};
`endif

  // Prioritised stall/flush: memory freeze, then taken branch, then data hazard.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (mem_freeze_s) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (data_stall_s) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end else begin
      StallF = 1'b0;
    end
  end

  // Memory wait tracker: enter on a miss, leave when memory reports ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RUN;
    end else begin
      case (state_r)
        RUN: begin
          if (MemReqM && !MemReadyM) begin
            state_r <= MEM_WAIT;
          end else begin
            state_r <= RUN;
          end
        end
        MEM_WAIT: begin
          if (MemReadyM) begin
            state_r <= RUN;
          end else begin
            state_r <= MEM_WAIT;
          end
        end
        default: state_r <= RUN;
      endcase
    end
  end

  // Stalled-fetch cycle counter; wraps naturally at 32 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_r <= 32'd0;
    end else if (StallF) begin
      stall_count_r <= stall_count_r + 32'd1;
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  assign StallCount = stall_count_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized checking of hazard_ctrl against
// a rule-level reference model. Follows HAZARD_FORWARDING_EN like the DUT.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        RegWriteE, RegWriteM, RegWriteW, ResultSrcE, PCSrcE;
  logic        MemReqM, MemReadyM;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] StallCount;

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  typedef struct packed {
    logic sf, sd, se, sm, fd, fe, fw;
    logic [1:0] fa, fb;
  } exp_t;

  logic        m_wait;
  logic [31:0] m_cnt;
  exp_t        m_now;

  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Does a write to register rd affect the instruction in Decode?
  function automatic logic needs(input logic [4:0] rd);
    return rd != 5'd0 && (rd == Rs1D || rd == Rs2D);
  endfunction

  function automatic logic [1:0] pick(input logic [4:0] rs);
    if (RegWriteM && RdM != 5'd0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 5'd0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Expected outputs from the hazard rules and whether memory is outstanding.
  function automatic exp_t model_out(input logic waiting);
    exp_t e;
    logic freeze, dstall;
    e = '0;
    freeze = !MemReadyM && (MemReqM || waiting);
`ifdef HAZARD_FORWARDING_EN
    dstall = ResultSrcE && needs(RdE);
    e.fa = pick(Rs1E);
    e.fb = pick(Rs2E);
`else
    dstall = (RegWriteE && needs(RdE)) || (RegWriteM && needs(RdM));
`endif
    if (freeze) begin
      e.sf = 1'b1; e.sd = 1'b1; e.se = 1'b1; e.sm = 1'b1; e.fw = 1'b1;
    end else if (PCSrcE) begin
      e.fd = 1'b1; e.fe = 1'b1;
    end else if (dstall) begin
      e.sf = 1'b1; e.sd = 1'b1; e.fe = 1'b1;
    end
    return e;
  endfunction

  always_comb m_now = model_out(m_wait);

  // Reference state: outstanding-memory flag and stall counter.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wait <= 1'b0;
      m_cnt  <= 32'd0;
    end else begin
      m_wait <= m_wait ? !MemReadyM : (MemReqM && !MemReadyM);
      if (m_now.sf) m_cnt <= m_cnt + 32'd1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("StallF", {31'd0, StallF}, {31'd0, m_now.sf});
      check("StallD", {31'd0, StallD}, {31'd0, m_now.sd});
      check("StallE", {31'd0, StallE}, {31'd0, m_now.se});
      check("StallM", {31'd0, StallM}, {31'd0, m_now.sm});
      check("FlushD", {31'd0, FlushD}, {31'd0, m_now.fd});
      check("FlushE", {31'd0, FlushE}, {31'd0, m_now.fe});
      check("FlushW", {31'd0, FlushW}, {31'd0, m_now.fw});
      check("ForwardAE", {30'd0, ForwardAE}, {30'd0, m_now.fa});
      check("ForwardBE", {30'd0, ForwardBE}, {30'd0, m_now.fb});
      check("StallCount", StallCount, m_cnt);
    end
  end

  task automatic clear_inputs();
    Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
    RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    ResultSrcE = 1'b0; PCSrcE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic set_load();
    RdE = 5'd5; Rs1D = 5'd5; ResultSrcE = 1'b1; RegWriteE = 1'b1;
  endtask

  task automatic rand_inputs();
    Rs1D = 5'($urandom_range(0, 7)); Rs2D = 5'($urandom_range(0, 7));
    Rs1E = 5'($urandom_range(0, 7)); Rs2E = 5'($urandom_range(0, 7));
    RdE  = 5'($urandom_range(0, 7)); RdM  = 5'($urandom_range(0, 7));
    RdW  = 5'($urandom_range(0, 7));
    RegWriteE  = 1'($urandom_range(0, 1));
    RegWriteM  = 1'($urandom_range(0, 1));
    RegWriteW  = 1'($urandom_range(0, 1));
    ResultSrcE = 1'($urandom_range(0, 1));
    PCSrcE     = ($urandom_range(0, 7) == 0);
    MemReqM    = ($urandom_range(0, 3) == 0);
    MemReadyM  = ($urandom_range(0, 2) != 0);
  endtask

  initial begin
    clear_inputs();
    chk_en = 1'b1;
    #22;
    check("reset_count", StallCount, 32'd0);
    check("reset_stallF", {31'd0, StallF}, 32'd0);
    rst_n = 1'b1;

    // Load-use hazard: one stalled cycle.
    tick(); set_load();
    mid();
    check("load_stallF", {31'd0, StallF}, 32'd1);
    check("load_stallD", {31'd0, StallD}, 32'd1);
    check("load_flushE", {31'd0, FlushE}, 32'd1);
    tick(); clear_inputs();
    mid();
    check("load_count", StallCount, 32'd1);
    check("load_one_cycle", {31'd0, StallF}, 32'd0);

    // Same hazard with a taken branch: branch wins, no stall counted.
    tick(); set_load(); PCSrcE = 1'b1;
    mid();
    check("br_flushD", {31'd0, FlushD}, 32'd1);
    check("br_flushE", {31'd0, FlushE}, 32'd1);
    check("br_stallF", {31'd0, StallF}, 32'd0);
    tick(); clear_inputs();
    mid();
    check("br_count", StallCount, 32'd1);

    // Three-cycle memory miss.
    tick(); MemReqM = 1'b1; MemReadyM = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mid();
      check("miss_stallF", {31'd0, StallF}, 32'd1);
      check("miss_stallM", {31'd0, StallM}, 32'd1);
      check("miss_flushW", {31'd0, FlushW}, 32'd1);
      check("miss_flushD", {31'd0, FlushD}, 32'd0);
      tick();
    end
    MemReadyM = 1'b1;
    mid();
    check("ready_stallF", {31'd0, StallF}, 32'd0);
    tick(); clear_inputs();
    mid();
    check("miss_count", StallCount, 32'd4);
    check("back_to_run", {31'd0, StallF}, 32'd0);

    // Forwarding priority.
    tick();
    RdM = 5'd7; RdW = 5'd7; RegWriteM = 1'b1; RegWriteW = 1'b1;
    Rs1E = 5'd7; Rs2E = 5'd0;
    mid();
`ifdef HAZARD_FORWARDING_EN
    check("fwdA_mem", {30'd0, ForwardAE}, 32'd2);
`else
    check("fwdA_off", {30'd0, ForwardAE}, 32'd0);
`endif
    check("fwdB_x0", {30'd0, ForwardBE}, 32'd0);
    tick(); RegWriteM = 1'b0;
    mid();
`ifdef HAZARD_FORWARDING_EN
    check("fwdA_wb", {30'd0, ForwardAE}, 32'd1);
`else
    check("fwdA_off2", {30'd0, ForwardAE}, 32'd0);
`endif

    // Non-load ALU dependency in Execute.
    tick(); clear_inputs();
    RegWriteE = 1'b1; RdE = 5'd3; Rs2D = 5'd3; Rs2E = 5'd3; RdM = 5'd3; RegWriteM = 1'b1;
    mid();
`ifdef HAZARD_FORWARDING_EN
    check("alu_nostall", {31'd0, StallF}, 32'd0);
    check("alu_fwdB", {30'd0, ForwardBE}, 32'd2);
`else
    check("raw_stallF", {31'd0, StallF}, 32'd1);
    check("raw_stallD", {31'd0, StallD}, 32'd1);
    check("raw_flushE", {31'd0, FlushE}, 32'd1);
    check("raw_fwdB", {30'd0, ForwardBE}, 32'd0);
`endif

    // Asynchronous reset while waiting on memory.
    tick(); clear_inputs(); MemReqM = 1'b1;
    tick(); MemReqM = 1'b0;
    mid();
    check("wait_stallF", {31'd0, StallF}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_count", StallCount, 32'd0);
    check("async_run", {31'd0, StallF}, 32'd0);
    #1 rst_n = 1'b1;

    // Counter wrap from all-ones.
    chk_en = 1'b0;
    mid();
    force dut.stall_count_r = 32'hFFFF_FFFF;
    #1 release dut.stall_count_r;
    set_load();
    tick(); clear_inputs();
    mid();
    check("wrap_count", StallCount, 32'd0);
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    // Randomized traffic with occasional asynchronous resets.
    for (int c = 0; c < 3000; c++) begin
      tick();
      rand_inputs();
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end

    mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
